// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the 3-bit CPU control unit.
//   seq_state_e  : sequencer states (exported on the debug port of the top)
//   IP_W         : instruction-pointer width
//   RET_W        : retired-instruction counter width
//   next_ip()    : candidate next ip with one extra bit, so running off the
//                  end of the program is visible instead of wrapping
package instruction_sequencer_pkg;

  localparam int IP_W          = 4;
  localparam int RET_W         = 8;
  localparam int PROG_LEN_DEF  = 16;
  localparam int MAX_INSTR_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HALT  = 3'd4
  } seq_state_e;

  // Instructions are two 3-bit words wide, so sequential flow advances by 2.
  function automatic logic [IP_W:0] next_ip(input logic [IP_W-1:0] ip,
                                            input logic            taken,
                                            input logic [IP_W-1:0] target);
    return taken ? {1'b0, target} : ({1'b0, ip} + (IP_W + 1)'(2));
  endfunction

endpackage

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: control unit for the 3-bit CPU.
// Steps instruction_fetch through the program, hands each fetched
// instruction to the execute unit and stops at program end, on a misaligned
// jump target, or when the retired-instruction budget is used up.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         begin a run from ip 0 (only honoured in IDLE/HALT)
//   exec_busy_i     execute unit still working on the current instruction
//   jump_taken_i    current instruction redirects ip (valid at completion)
//   jump_target_i   redirect target (valid with jump_taken_i)
//   instr_ptr_o     ip presented to instruction_fetch
//   halt_if_o       0 only in FETCH: fetch registers load on that edge
//   exec_valid_o    one-cycle pulse: fetched opcode/operand are new
//   running_o       1 in FETCH/EXEC/WAIT
//   done_o          1 in HALT
//   err_align_o     sticky: run halted on an odd jump target
//   err_timeout_o   sticky: run halted on the instruction budget
//   retired_o       instructions completed this run (saturating)
//   state_o         current FSM state (debug)
//
// Execute handshake: exec_valid_o marks the single cycle in which a new
// instruction is offered. From that cycle on the execute unit holds
// exec_busy_i high while it works; the first cycle with exec_busy_i low is
// the completion cycle, and jump_taken_i/jump_target_i are sampled on that
// same edge. exec_busy_i and the jump inputs are ignored in all other states.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int PROG_LEN  = PROG_LEN_DEF,
  parameter int MAX_INSTR = MAX_INSTR_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             exec_busy_i,
  input  logic             jump_taken_i,
  input  logic [IP_W-1:0]  jump_target_i,
  output logic [IP_W-1:0]  instr_ptr_o,
  output logic             halt_if_o,
  output logic             exec_valid_o,
  output logic             running_o,
  output logic             done_o,
  output logic             err_align_o,
  output logic             err_timeout_o,
  output logic [RET_W-1:0] retired_o,
  output seq_state_e       state_o
);

  seq_state_e       state_q, state_d;
  logic [IP_W-1:0]  ip_q, ip_d;
  logic [RET_W-1:0] retired_q, retired_d;
  logic             err_align_q, err_align_d;
  logic             err_timeout_q, err_timeout_d;

  logic [IP_W:0]    nip;
  logic [RET_W-1:0] ret_inc;
  logic             complete;

  assign nip      = next_ip(ip_q, jump_taken_i, jump_target_i);
  assign ret_inc  = (retired_q == {RET_W{1'b1}}) ? retired_q : retired_q + RET_W'(1);
  assign complete = ((state_q == ST_EXEC) || (state_q == ST_WAIT)) && !exec_busy_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ip_q          <= '0;
      retired_q     <= '0;
      err_align_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ip_q          <= ip_d;
      retired_q     <= retired_d;
      err_align_q   <= err_align_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ip_d          = ip_q;
    retired_d     = retired_q;
    err_align_d   = err_align_q;
    err_timeout_d = err_timeout_q;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start_i) begin
          state_d       = ST_FETCH;
          ip_d          = '0;
          retired_d     = '0;
          err_align_d   = 1'b0;
          err_timeout_d = 1'b0;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC:  if (exec_busy_i) state_d = ST_WAIT;
      ST_WAIT:  ;
      default:  state_d = ST_IDLE;
    endcase

    // Completion: misalignment wins over the budget, the budget over normal end.
    if (complete) begin
      retired_d = ret_inc;
      if (jump_taken_i && jump_target_i[0]) begin
        state_d     = ST_HALT;
        err_align_d = 1'b1;
      end else if (ret_inc == RET_W'(MAX_INSTR)) begin
        state_d       = ST_HALT;
        err_timeout_d = 1'b1;
        ip_d          = nip[IP_W-1:0];
      end else if (nip >= (IP_W + 1)'(PROG_LEN)) begin
        state_d = ST_HALT;
        ip_d    = nip[IP_W-1:0];
      end else begin
        state_d = ST_FETCH;
        ip_d    = nip[IP_W-1:0];
      end
    end
  end

  assign instr_ptr_o   = ip_q;
  assign halt_if_o     = (state_q != ST_FETCH);
  assign exec_valid_o  = (state_q == ST_EXEC);
  assign running_o     = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_WAIT);
  assign done_o        = (state_q == ST_HALT);
  assign err_align_o   = err_align_q;
  assign err_timeout_o = err_timeout_q;
  assign retired_o     = retired_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
module tb_instruction_sequencer;
  import instruction_sequencer_pkg::*;

  localparam int PL  = 8;
  localparam int MI  = 10;
  localparam int TMO = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_i = 0, exec_busy_i = 0, jump_taken_i = 0;
  logic [3:0]  jump_target_i = 0;
  logic [3:0]  instr_ptr_o;
  logic        halt_if_o, exec_valid_o, running_o, done_o, err_align_o, err_timeout_o;
  logic [7:0]  retired_o;
  seq_state_e  state_o;

  instruction_sequencer #(.PROG_LEN(PL), .MAX_INSTR(MI)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .exec_busy_i(exec_busy_i),
    .jump_taken_i(jump_taken_i), .jump_target_i(jump_target_i),
    .instr_ptr_o(instr_ptr_o), .halt_if_o(halt_if_o), .exec_valid_o(exec_valid_o),
    .running_o(running_o), .done_o(done_o), .err_align_o(err_align_o),
    .err_timeout_o(err_timeout_o), .retired_o(retired_o), .state_o(state_o)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];   // {gap since previous issue (cycles), ip}
  logic [13:0] res_q[$];   // {err_align, err_timeout, retired, final ip}
  logic [13:0] fin_exp;
  int unsigned last_ev = 0;

  // Per-instruction execute behaviour, indexed by retire order.
  int         d_busy[MI];
  bit         d_jt[MI];
  logic [3:0] d_tgt[MI];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur within bound (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  // Walks the program as the CPU architecture defines it and queues the
  // expected issue sequence plus the final outcome.
  task automatic run_model(output int n);
    int ip, ret, nip, gap, k;
    logic [13:0] r;
    ip = 0; ret = 0; gap = 2; k = 0;
    forever begin
      exp_q.push_back({8'(gap), 4'(ip)});
      ret = ret + 1;
      nip = d_jt[k] ? int'(d_tgt[k]) : ip + 2;
      gap = d_busy[k] + 2;
      if (d_jt[k] && d_tgt[k][0]) begin
        r = {1'b1, 1'b0, 8'(ret), 4'(ip)}; k++; break;
      end else if (ret == MI) begin
        r = {1'b0, 1'b1, 8'(ret), 4'(nip % 16)}; k++; break;
      end else if (nip >= PL) begin
        r = {1'b0, 1'b0, 8'(ret), 4'(nip % 16)}; k++; break;
      end
      ip = nip;
      k++;
    end
    res_q.push_back(r);
    fin_exp = r;
    n = k;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [11:0] e;
    logic [13:0] r;
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (exec_valid_o) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_exec: got issue at ip %0h expected none", instr_ptr_o);
          end else begin
            e = exp_q.pop_front();
            check("exec_ip", 32'(instr_ptr_o), 32'(e[3:0]));
            check("exec_gap", 32'(cyc - last_ev), 32'(e[11:4]));
            check("exec_halt_if", 32'(halt_if_o), 32'd1);
          end
          last_ev = cyc;
        end
        if (done_o && !done_prev) begin
          if (res_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done expected none");
          end else begin
            r = res_q.pop_front();
            check("end_err_align", 32'(err_align_o), 32'(r[13]));
            check("end_err_timeout", 32'(err_timeout_o), 32'(r[12]));
            check("end_retired", 32'(retired_o), 32'(r[11:4]));
            check("end_ip", 32'(instr_ptr_o), 32'(r[3:0]));
            check("end_running", 32'(running_o), 32'd0);
          end
        end
        done_prev = done_o;
      end else begin
        done_prev = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_dec();
    for (int k = 0; k < MI; k++) begin
      d_busy[k] = 0; d_jt[k] = 0; d_tgt[k] = '0;
    end
  endtask

  task automatic idle_inputs();
    start_i = 0; exec_busy_i = 0; jump_taken_i = 0; jump_target_i = '0;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    res_q.delete();
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic wait_exec(output bit ok);
    ok = 0;
    for (int i = 0; i < TMO; i++) begin
      if (exec_valid_o) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  // Acts as the execute unit for instruction k; returns in the cycle after completion.
  task automatic service(input int k, input bit poke);
    int b;
    b = d_busy[k];
    jump_taken_i  = d_jt[k];
    jump_target_i = d_jt[k] ? d_tgt[k] : 4'($urandom_range(0, 15));
    exec_busy_i   = (b > 0);
    start_i       = poke;   // must be ignored while running
    for (int c = 0; c < b; c++) begin
      @(negedge clk);
      start_i     = 0;
      exec_busy_i = (c + 1 < b);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_run(input bit poke_en);
    int n;
    bit ok;
    run_model(n);
    @(negedge clk);
    start_i = 1;
    last_ev = cyc;
    @(negedge clk);
    start_i = 0;
    // First cycle of the run: FETCH with all run state cleared.
    check("fetch_halt_if", 32'(halt_if_o), 32'd0);
    check("fetch_running", 32'(running_o), 32'd1);
    check("fetch_ip", 32'(instr_ptr_o), 32'd0);
    check("fetch_cleared", {22'd0, err_align_o, err_timeout_o, retired_o}, 32'd0);
    for (int k = 0; k < n; k++) begin
      wait_exec(ok);
      if (!ok) begin
        flag_fail("exec_valid_wait");
        hard_reset();
        return;
      end
      service(k, poke_en && ($urandom_range(0, 1) == 1));
    end
    ok = 0;
    for (int i = 0; i < TMO; i++) begin
      if (done_o) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      flag_fail("done_wait");
      hard_reset();
      return;
    end
    // HALT must ignore execute-side inputs and keep its outputs.
    for (int i = 0; i < 3; i++) begin
      exec_busy_i   = 1'($urandom_range(0, 1));
      jump_taken_i  = 1'($urandom_range(0, 1));
      jump_target_i = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    idle_inputs();
    check("halt_frozen", {18'd0, done_o, err_align_o, err_timeout_o, retired_o, instr_ptr_o},
          {18'd0, 1'b1, fin_exp});
    check("queues_drained", 32'(exp_q.size() + res_q.size()), 32'd0);
    exp_q.delete();
    res_q.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, 32'(state_o), 32'(ST_IDLE));
    check({tag, "_ip"}, 32'(instr_ptr_o), 32'd0);
    check({tag, "_flags"}, {27'd0, halt_if_o, exec_valid_o, running_o, done_o, 1'b0},
          {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    check({tag, "_cleared"}, {22'd0, err_align_o, err_timeout_o, retired_o}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1;
    repeat (2) @(negedge clk);
    check_idle("idle_hold");

    // Linear program to the end.
    clear_dec();
    do_run(1'b0);

    // One multi-cycle instruction at ip 2.
    clear_dec();
    d_busy[1] = 3;
    do_run(1'b0);

    // Backward jnz at ip 6 taken once, with start pokes while running.
    clear_dec();
    d_jt[3] = 1; d_tgt[3] = 4'd0;
    do_run(1'b1);

    // Odd jump target from ip 2.
    clear_dec();
    d_jt[1] = 1; d_tgt[1] = 4'd5;
    do_run(1'b0);

    // Endless self-loop hits the budget.
    clear_dec();
    for (int k = 0; k < MI; k++) begin d_jt[k] = 1; d_tgt[k] = 4'd0; end
    do_run(1'b0);

    // Reset while halted with sticky error and non-zero count.
    @(negedge clk);
    rst_n = 0;
    #1;
    check_idle("rst_halt");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Reset while waiting on a busy instruction.
    clear_dec();
    exp_q.push_back({8'd2, 4'd0});
    exp_q.push_back({8'd2, 4'd2});
    @(negedge clk);
    start_i = 1;
    last_ev = cyc;
    @(negedge clk);
    start_i = 0;
    wait_exec(ok);
    if (!ok) flag_fail("rst_wait_exec0");
    service(0, 1'b0);
    wait_exec(ok);
    if (!ok) flag_fail("rst_wait_exec1");
    exec_busy_i = 1;
    repeat (2) @(negedge clk);
    check("wait_state", 32'(state_o), 32'(ST_WAIT));
    check("wait_ip", 32'(instr_ptr_o), 32'd2);
    #2;
    rst_n = 0;
    #1;
    check_idle("rst_wait");
    idle_inputs();
    exp_q.delete();
    res_q.delete();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Randomized programs.
    for (int r = 0; r < 30; r++) begin
      clear_dec();
      for (int k = 0; k < MI; k++) begin
        d_busy[k] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
        d_jt[k]   = ($urandom_range(0, 3) == 0);
        d_tgt[k]  = ($urandom_range(0, 9) == 0) ? 4'(2 * $urandom_range(0, 7) + 1)
                                                : 4'(2 * $urandom_range(0, 7));
      end
      do_run(1'b1);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
